// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: icache request/response, EXE redirect and decode handshake.
// master = fetch unit (ifetch_queue), slave = icache/EXE/decode side.
interface ifetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            icache_req_v_o;
  logic            icache_req_rdy_i;
  logic [XLEN-1:0] icache_adr_o;
  logic            icache_rsp_v_i;
  logic [31:0]     icache_instr_i;
  logic            branch_v_q_i;
  logic            exception_q_i;
  logic [XLEN-1:0] pc_data_q_i;
  logic            instr_v_o;
  logic            dec_ready_i;
  logic [31:0]     instr_q_o;
  logic [XLEN-1:0] pc_q_o;

  modport master (
    output icache_req_v_o, icache_adr_o, instr_v_o, instr_q_o, pc_q_o,
    input  icache_req_rdy_i, icache_rsp_v_i, icache_instr_i,
           branch_v_q_i, exception_q_i, pc_data_q_i, dec_ready_i
  );

  modport slave (
    input  icache_req_v_o, icache_adr_o, instr_v_o, instr_q_o, pc_q_o,
    output icache_req_rdy_i, icache_rsp_v_i, icache_instr_i,
           branch_v_q_i, exception_q_i, pc_data_q_i, dec_ready_i
  );
endinterface

// File: rtl/ifetch_queue.sv
// Sequential instruction fetch with credit-limited icache requests and a DEPTH-entry
// {pc, instr} decode queue; redirects flush the queue and turn in-flight responses into discards.
module ifetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] reset_adr_i,
  ifetch_queue_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = XLEN + 32;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic             reset_n_q, reset_n_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];

  logic             redirect_c;
  logic [SUM_W-1:0] credit_sum_c;
  logic             req_v_c;
  logic             req_hs_c;
  logic             drop_c;
  logic             push_c;
  logic             pop_c;

  // Handshake decode; queued plus in-flight fetches never exceed DEPTH, so a push always fits.
  always_comb begin
    redirect_c   = reset_n_q & (bus.branch_v_q_i | bus.exception_q_i);
    credit_sum_c = SUM_W'(occ_q) + SUM_W'(outstanding_q);
    req_v_c      = reset_n_q & ~redirect_c & (credit_sum_c < SUM_W'(DEPTH));
    req_hs_c     = req_v_c & bus.icache_req_rdy_i;
    drop_c       = bus.icache_rsp_v_i & (discard_q != '0);
    push_c       = bus.icache_rsp_v_i & ~drop_c & ~redirect_c;
    pop_c        = (occ_q != '0) & bus.dec_ready_i & ~redirect_c;
  end

  always_comb begin
    reset_n_d     = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    occ_d         = occ_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;

    if (!reset_n_q) begin
      fetch_pc_d = reset_adr_i;
      rsp_pc_d   = reset_adr_i;
    end else begin
      outstanding_d = outstanding_q + CNT_W'(req_hs_c) - CNT_W'(bus.icache_rsp_v_i);
      if (redirect_c) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc_d = bus.pc_data_q_i;
        rsp_pc_d   = bus.pc_data_q_i;
        discard_d  = outstanding_q - CNT_W'(bus.icache_rsp_v_i);
        occ_d      = '0;
        rd_ptr_d   = '0;
        wr_ptr_d   = '0;
      end else begin
        if (req_hs_c) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (drop_c)   discard_d  = discard_q - CNT_W'(1);
        if (push_c) begin
          mem_d[wr_ptr_q] = {rsp_pc_q, bus.icache_instr_i};
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
          rsp_pc_d        = rsp_pc_q + XLEN'(4);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        occ_d = occ_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reset_n_q     <= 1'b0;
      fetch_pc_q    <= '0;
      rsp_pc_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      occ_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      reset_n_q     <= reset_n_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      occ_q         <= occ_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_q         <= mem_d;
    end
  end

  assign bus.icache_req_v_o           = req_v_c;
  assign bus.icache_adr_o             = fetch_pc_q;
  assign bus.instr_v_o                = (occ_q != '0);
  assign {bus.pc_q_o, bus.instr_q_o}  = mem_q[rd_ptr_q];

  // Counter sanity: no response without a request, credits and discards stay bounded.
  a_rsp_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    bus.icache_rsp_v_i |-> (outstanding_q != '0));
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    credit_sum_c <= SUM_W'(DEPTH));
  a_discard_bound: assert property (@(posedge clk) disable iff (!reset_n)
    discard_q <= outstanding_q);

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue: an in-order icache responder plus a queue-level model
// of fetch addresses, credit, queued entries and redirect discards.
module tb_ifetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic [31:0] reset_adr;

  ifetch_queue_if #(.XLEN(XLEN)) bus ();

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .reset_adr_i (reset_adr),
    .bus         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  int          cyc;
  int          lat;
  bit          rand_lat;
  int          hs_cnt;
  bit          booted;
  bit          prev_stall;
  logic [31:0] prev_adr;
  logic [31:0] exp_fetch;
  logic [31:0] pend_adr[$];
  int          pend_due[$];
  bit          pend_stale[$];
  logic [31:0] mq[$];
  logic [31:0] popped[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  task automatic enter_reset(input logic [31:0] adr);
    reset_n                = 1'b0;
    reset_adr              = adr;
    bus.icache_req_rdy_i   = 1'b1;
    bus.icache_rsp_v_i     = 1'b0;
    bus.icache_instr_i     = '0;
    bus.branch_v_q_i       = 1'b0;
    bus.exception_q_i      = 1'b0;
    bus.pc_data_q_i        = '0;
    bus.dec_ready_i        = 1'b1;
    pend_adr.delete();
    pend_due.delete();
    pend_stale.delete();
    mq.delete();
    popped.delete();
    booted     = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One clock: drive the responder, check outputs at negedge against the model, advance the model.
  task automatic step();
    bit          deliver, redir, exp_req_v, exp_iv, hs, pop, st;
    logic [31:0] a;
    deliver = (pend_adr.size() != 0) && (pend_due[0] <= cyc);
    bus.icache_rsp_v_i = deliver;
    bus.icache_instr_i = deliver ? instr_of(pend_adr[0]) : $urandom;
    @(negedge clk);
    redir     = booted && (bus.branch_v_q_i || bus.exception_q_i);
    exp_req_v = booted && !redir && ((mq.size() + pend_adr.size()) < int'(DEPTH));
    exp_iv    = (mq.size() != 0);
    total++;
    if (bus.icache_req_v_o !== exp_req_v) begin
      bad++;
      $display("FAIL req_v cyc=%0d got=%b exp=%b", cyc, bus.icache_req_v_o, exp_req_v);
    end
    total++;
    if (bus.instr_v_o !== exp_iv) begin
      bad++;
      $display("FAIL instr_v cyc=%0d got=%b exp=%b", cyc, bus.instr_v_o, exp_iv);
    end
    if (exp_iv) begin
      total++;
      if (bus.pc_q_o !== mq[0] || bus.instr_q_o !== instr_of(mq[0])) begin
        bad++;
        $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                 cyc, bus.pc_q_o, bus.instr_q_o, mq[0], instr_of(mq[0]));
      end
    end
    if (prev_stall) begin
      total++;
      if (bus.icache_adr_o !== prev_adr) begin
        bad++;
        $display("FAIL adr_hold cyc=%0d got=%h exp=%h", cyc, bus.icache_adr_o, prev_adr);
      end
    end
    hs = (bus.icache_req_v_o === 1'b1) && bus.icache_req_rdy_i;
    if (hs) begin
      total++;
      if (bus.icache_adr_o !== exp_fetch) begin
        bad++;
        $display("FAIL fetch_adr cyc=%0d got=%h exp=%h", cyc, bus.icache_adr_o, exp_fetch);
      end
      exp_fetch = exp_fetch + 32'd4;
      hs_cnt++;
    end
    pop = exp_iv && bus.dec_ready_i && !redir;
    if (pop) begin
      popped.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (deliver) begin
      a  = pend_adr.pop_front();
      st = pend_stale.pop_front();
      void'(pend_due.pop_front());
      if (!st && !redir) mq.push_back(a);
    end
    if (redir) begin
      mq.delete();
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
      exp_fetch = bus.pc_data_q_i;
    end
    if (hs) begin
      pend_adr.push_back(bus.icache_adr_o);
      pend_due.push_back(cyc + (rand_lat ? int'($urandom_range(4, 1)) : lat));
      pend_stale.push_back(1'b0);
    end
    if (!booted) begin
      booted    = 1'b1;
      exp_fetch = reset_adr;
    end
    prev_stall = (bus.icache_req_v_o === 1'b1) && !bus.icache_req_rdy_i;
    prev_adr   = bus.icache_adr_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    lat = 1; rand_lat = 1'b0;
    enter_reset(32'h8000_0000);
    total++; if (bus.icache_req_v_o !== 1'b0) begin bad++; $display("FAIL rst_req_v got=%b exp=0", bus.icache_req_v_o); end
    total++; if (bus.icache_adr_o !== 32'h0) begin bad++; $display("FAIL rst_adr got=%h exp=0", bus.icache_adr_o); end
    total++; if (bus.instr_v_o !== 1'b0) begin bad++; $display("FAIL rst_instr_v got=%b exp=0", bus.instr_v_o); end
    total++; if (bus.instr_q_o !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", bus.instr_q_o); end
    total++; if (bus.pc_q_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.pc_q_o); end
    reset_n = 1'b1;
    step();
    total++;
    if (bus.icache_req_v_o !== 1'b1 || bus.icache_adr_o !== 32'h8000_0000) begin
      bad++;
      $display("FAIL first_req got v=%b adr=%h exp v=1 adr=80000000", bus.icache_req_v_o, bus.icache_adr_o);
    end
  endtask

  task automatic test_boot_stream();
    int n0;
    repeat (10) step();
    n0 = popped.size();
    repeat (30) step();
    total++;
    if (popped.size() - n0 != 30) begin
      bad++;
      $display("FAIL throughput got=%0d pops exp=30", popped.size() - n0);
    end
    total++;
    if (popped.size() < 3 || popped[0] !== 32'h8000_0000 || popped[1] !== 32'h8000_0004 ||
        popped[2] !== 32'h8000_0008) begin
      bad++;
      $display("FAIL boot_order got=%h,%h,%h exp=80000000,80000004,80000008", popped[0], popped[1], popped[2]);
    end
  endtask

  task automatic test_backpressure();
    int h0;
    enter_reset(32'h0000_1000);
    bus.dec_ready_i = 1'b0;
    reset_n = 1'b1;
    h0 = hs_cnt;
    repeat (12) step();
    total++; if (hs_cnt - h0 != int'(DEPTH)) begin bad++; $display("FAIL bp_fetches got=%0d exp=%0d", hs_cnt - h0, DEPTH); end
    total++; if (bus.icache_req_v_o !== 1'b0) begin bad++; $display("FAIL bp_req_v got=%b exp=0", bus.icache_req_v_o); end
    total++; if (bus.instr_v_o !== 1'b1 || bus.pc_q_o !== 32'h1000) begin
      bad++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=00001000", bus.instr_v_o, bus.pc_q_o);
    end
    bus.dec_ready_i = 1'b1;
    step();
    total++;
    if (bus.icache_req_v_o !== 1'b1 || bus.icache_adr_o !== 32'h1010) begin
      bad++; $display("FAIL bp_resume got v=%b adr=%h exp v=1 adr=00001010", bus.icache_req_v_o, bus.icache_adr_o);
    end
    repeat (12) step();
    total++;
    if (popped.size() < 5 || popped[0] !== 32'h1000 || popped[3] !== 32'h100C || popped[4] !== 32'h1010) begin
      bad++; $display("FAIL bp_order got=%h,%h,%h exp=00001000,0000100c,00001010", popped[0], popped[3], popped[4]);
    end
  endtask

  task automatic test_redirect_inflight();
    enter_reset(32'h0000_2000);
    lat = 3;
    reset_n = 1'b1;
    repeat (3) step();
    total++; if (pend_adr.size() != 2) begin bad++; $display("FAIL rd_setup got=%0d outstanding exp=2", pend_adr.size()); end
    bus.branch_v_q_i = 1'b1;
    bus.pc_data_q_i  = 32'h0000_0100;
    step();
    bus.branch_v_q_i = 1'b0;
    total++;
    if (bus.instr_v_o !== 1'b0 || bus.icache_adr_o !== 32'h100) begin
      bad++; $display("FAIL rd_target got v=%b adr=%h exp v=0 adr=00000100", bus.instr_v_o, bus.icache_adr_o);
    end
    popped.delete();
    repeat (15) step();
    total++;
    if (popped.size() < 2 || popped[0] !== 32'h100 || popped[1] !== 32'h104) begin
      bad++; $display("FAIL rd_first got=%h,%h exp=00000100,00000104", popped[0], popped[1]);
    end
  endtask

  task automatic test_double_redirect();
    lat = 1;
    repeat (6) step();
    total++; if (bus.instr_v_o !== 1'b1) begin bad++; $display("FAIL dr_pre got v=%b exp=1", bus.instr_v_o); end
    bus.branch_v_q_i  = 1'b1;
    bus.exception_q_i = 1'b1;
    bus.pc_data_q_i   = 32'h0000_4000;
    step();
    bus.branch_v_q_i  = 1'b0;
    bus.exception_q_i = 1'b0;
    total++;
    if (bus.instr_v_o !== 1'b0 || bus.icache_adr_o !== 32'h4000) begin
      bad++; $display("FAIL dr_flush got v=%b adr=%h exp v=0 adr=00004000", bus.instr_v_o, bus.icache_adr_o);
    end
    popped.delete();
    repeat (8) step();
    total++;
    if (popped.size() < 2 || popped[0] !== 32'h4000 || popped[1] !== 32'h4004) begin
      bad++; $display("FAIL dr_first got=%h,%h exp=00004000,00004004", popped[0], popped[1]);
    end
  endtask

  task automatic test_rdy_random();
    rand_lat = 1'b1;
    popped.delete();
    for (int i = 0; i < 600; i++) begin
      bus.icache_req_rdy_i = $urandom_range(1, 0) != 0;
      bus.dec_ready_i      = $urandom_range(3, 0) != 0;
      bus.branch_v_q_i     = $urandom_range(39, 0) == 0;
      bus.exception_q_i    = $urandom_range(59, 0) == 0;
      bus.pc_data_q_i      = $urandom & 32'hFFFF_FFFC;
      step();
    end
    bus.branch_v_q_i     = 1'b0;
    bus.exception_q_i    = 1'b0;
    bus.icache_req_rdy_i = 1'b1;
    bus.dec_ready_i      = 1'b1;
    rand_lat = 1'b0;
    total++;
    if (popped.size() <= 40) begin bad++; $display("FAIL rnd_progress got=%0d pops exp>40", popped.size()); end
  endtask

  task automatic test_wrap();
    enter_reset(32'hFFFF_FFF8);
    lat = 1;
    bus.branch_v_q_i = 1'b1;
    bus.pc_data_q_i  = 32'h0000_0500;
    reset_n = 1'b1;
    step();
    bus.branch_v_q_i = 1'b0;
    repeat (10) step();
    total++;
    if (popped.size() < 3 || popped[0] !== 32'hFFFF_FFF8 || popped[1] !== 32'hFFFF_FFFC ||
        popped[2] !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap got=%h,%h,%h exp=fffffff8,fffffffc,00000000", popped[0], popped[1], popped[2]);
    end
  endtask

  task automatic test_async_reset();
    lat = 2;
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.icache_req_v_o !== 1'b0 || bus.icache_adr_o !== 32'h0 || bus.instr_v_o !== 1'b0 ||
        bus.instr_q_o !== 32'h0 || bus.pc_q_o !== 32'h0) begin
      bad++;
      $display("FAIL async_rst got v=%b adr=%h iv=%b instr=%h pc=%h exp all 0",
               bus.icache_req_v_o, bus.icache_adr_o, bus.instr_v_o, bus.instr_q_o, bus.pc_q_o);
    end
    enter_reset(32'h0000_3000);
    reset_n = 1'b1;
    repeat (8) step();
    total++;
    if (popped.size() < 1 || popped[0] !== 32'h3000) begin
      bad++; $display("FAIL async_reboot got=%h exp=00003000", popped[0]);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; hs_cnt = 0;
    lat = 1; rand_lat = 1'b0;
    test_reset();
    test_boot_stream();
    test_backpressure();
    test_redirect_inflight();
    test_double_redirect();
    test_rdy_random();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
